// File: rtl/spi_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_pkg
// Shared definitions for the SPI master: FSM state encoding and SPI mode
// constants. The design implements mode 0 (CPOL=0, CPHA=0): SCK idles low,
// MISO is sampled on the leading (rising) edge, and MOSI changes on the
// trailing (falling) edge.
// -----------------------------------------------------------------------------
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic SPI_CPOL = 1'b0;  // SCK idle level
  localparam logic SPI_CPHA = 1'b0;  // 0: sample on leading edge

endpackage

// File: rtl/spi_sck_tick.sv
// -----------------------------------------------------------------------------
// spi_sck_tick
// Half-period tick generator. While en is high, tick pulses for one clk cycle
// every CLK_DIV cycles; the first pulse comes CLK_DIV cycles after en rises.
// While en is low the counter is held at zero so each enable starts a fresh,
// full-length period.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   en    - count enable (low reloads the counter)
//   tick  - one-cycle pulse at the end of each CLK_DIV-cycle period
// -----------------------------------------------------------------------------
module spi_sck_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  // A one-bit counter is kept even for CLK_DIV=1 so the width is never zero.
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Mode-0 SPI master that runs fixed-length frames: CMD_BITS command bits are
// shifted out MSB first on MOSI (zeros afterwards) while FRAME_BITS bits are
// captured from MISO (first bit lands in the MSB of o_rx_data).
// Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, each non-idle
// phase advancing on a half-period tick.
//
// Parameters: CMD_BITS, FRAME_BITS (>= CMD_BITS), CLK_DIV (>= 1, clk cycles
// per SCK half-period).
//
// Ports:
//   i_clk, i_rst_n - clock (rising edge) and asynchronous active-low reset
//   i_start        - frame request, only looked at in IDLE
//   i_cmd          - command word, captured when i_start is accepted
//   i_miso         - slave data in
//   i_abort        - (SPI_MASTER_ABORT_EN only) cancel the current frame
//   o_rx_data      - data of the last completed frame
//   o_rx_valid     - one-cycle pulse when o_rx_data updates
//   o_busy         - high whenever the FSM is outside IDLE
//   o_sck, o_mosi, o_ssel_n - SPI pins
//
// Build option: define SPI_MASTER_ABORT_EN to add the i_abort input. An abort
// in SETUP/SHIFT/HOLD drops the pins to idle on the next cycle and runs a full
// GAP without updating o_rx_data or pulsing o_rx_valid.
// -----------------------------------------------------------------------------
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CMD_BITS   = 16,
  parameter int FRAME_BITS = 128,
  parameter int CLK_DIV    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [CMD_BITS-1:0]   i_cmd,
  input  logic                  i_miso,
`ifdef SPI_MASTER_ABORT_EN
  input  logic                  i_abort,
`endif
  output logic [FRAME_BITS-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_busy,
  output logic                  o_sck,
  output logic                  o_mosi,
  output logic                  o_ssel_n
);

  // Sized to hold FRAME_BITS itself, so the count never wraps in a frame.
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS);

  state_t                  state, next_state;
  logic                    tick, tick_en, abort_hit, sample_edge;
  logic [BW-1:0]           bit_cnt;
  logic [CMD_BITS-1:0]     cmd_sr, cmd_shl;
  logic [FRAME_BITS-1:0]   rx_sr;
  logic                    sck, mosi, ssel_n;

`ifdef SPI_MASTER_ABORT_EN
  assign abort_hit = i_abort &&
                     (state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD);
`else
  assign abort_hit = 1'b0;
`endif

  // Dropping enable on an abort reloads the divider, so GAP gets a full tick.
  assign tick_en = (state != ST_IDLE) && !abort_hit;

  spi_sck_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (tick_en),
    .tick  (tick)
  );

  // With CPHA=0 the edge leaving the idle level is the sampling edge.
  assign sample_edge = (sck == SPI_CPOL) ^ SPI_CPHA;
  assign cmd_shl     = cmd_sr << 1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets its default first, so no path through the case
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (i_start) next_state = ST_SETUP;
      ST_SETUP: if (tick) next_state = ST_SHIFT;
      // The last trailing edge happens after FRAME_BITS sampling edges.
      ST_SHIFT: if (tick && !sample_edge && bit_cnt == LAST_BIT)
                  next_state = ST_HOLD;
      ST_HOLD:  if (tick) next_state = ST_GAP;
      ST_GAP:   if (tick) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    if (abort_hit) next_state = ST_GAP;
  end

  // Pins are registered so they change cleanly one cycle after the decision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck        <= SPI_CPOL;
      mosi       <= 1'b0;
      ssel_n     <= 1'b1;
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      rx_sr      <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            cmd_sr  <= i_cmd;
            mosi    <= i_cmd[CMD_BITS-1];
            ssel_n  <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            sck <= ~sck;
            if (sample_edge) begin
              rx_sr   <= {rx_sr[FRAME_BITS-2:0], i_miso};
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              // Zeros shift in behind the command, giving the idle-low tail.
              cmd_sr <= cmd_shl;
              mosi   <= cmd_shl[CMD_BITS-1];
            end
          end
        end
        ST_HOLD: begin
          // tick is already suppressed on an abort, so rx_data stays put.
          if (tick) begin
            ssel_n     <= 1'b1;
            mosi       <= 1'b0;
            o_rx_data  <= rx_sr;
            o_rx_valid <= 1'b1;
          end
        end
        default: ;
      endcase
      if (abort_hit) begin
        ssel_n <= 1'b1;
        sck    <= SPI_CPOL;
        mosi   <= 1'b0;
      end
    end
  end

  assign o_busy   = (state != ST_IDLE);
  assign o_sck    = sck;
  assign o_mosi   = mosi;
  assign o_ssel_n = ssel_n;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master. u_dut0 uses CLK_DIV=2, CMD_BITS=16,
// FRAME_BITS=128; u_dut1 uses CLK_DIV=1, CMD_BITS=FRAME_BITS=16 with i_start
// held high for back-to-back frames. A negedge monitor decodes MOSI on SCK
// rises, plays the slave (MISO changes after each rise), and records edge
// times. Define SPI_MASTER_ABORT_EN to include the abort scenario.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int D0 = 2;
  localparam int F0 = 128;
  localparam int C0 = 16;
  localparam int D1 = 1;
  localparam int F1 = 16;
  localparam int C1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0 ----------------
  logic            rst0_n, start0, miso0;
  logic [C0-1:0]   cmd0;
  logic [F0-1:0]   rx0;
  logic            valid0_o, busy0, sck0, mosi0, ssel0_n;
  logic [F0-1:0]   slave0;
`ifdef SPI_MASTER_ABORT_EN
  logic            abort0 = 1'b0;
`endif

  spi_master #(
    .CMD_BITS   (C0),
    .FRAME_BITS (F0),
    .CLK_DIV    (D0)
  ) u_dut0 (
    .i_clk      (clk),
    .i_rst_n    (rst0_n),
    .i_start    (start0),
    .i_cmd      (cmd0),
    .i_miso     (miso0),
`ifdef SPI_MASTER_ABORT_EN
    .i_abort    (abort0),
`endif
    .o_rx_data  (rx0),
    .o_rx_valid (valid0_o),
    .o_busy     (busy0),
    .o_sck      (sck0),
    .o_mosi     (mosi0),
    .o_ssel_n   (ssel0_n)
  );

  // ---------------- DUT 1 ----------------
  logic            rst1_n, start1, miso1;
  logic [C1-1:0]   cmd1;
  logic [F1-1:0]   rx1;
  logic            valid1_o, busy1, sck1, mosi1, ssel1_n;
  logic [F1-1:0]   slave1;
`ifdef SPI_MASTER_ABORT_EN
  logic            abort1 = 1'b0;
`endif

  spi_master #(
    .CMD_BITS   (C1),
    .FRAME_BITS (F1),
    .CLK_DIV    (D1)
  ) u_dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst1_n),
    .i_start    (start1),
    .i_cmd      (cmd1),
    .i_miso     (miso1),
`ifdef SPI_MASTER_ABORT_EN
    .i_abort    (abort1),
`endif
    .o_rx_data  (rx1),
    .o_rx_valid (valid1_o),
    .o_busy     (busy1),
    .o_sck      (sck1),
    .o_mosi     (mosi1),
    .o_ssel_n   (ssel1_n)
  );

  // ---------------- monitor / slave model ----------------
  int cyc = 0;
  // dut0
  int rises0 = 0, falls0 = 0, half_err0 = 0, frames0 = 0, valid0 = 0;
  int last_edge0 = 0, ssel_fall0 = 0, first_rise0 = 0, last_fall0 = 0;
  int ssel_rise0 = 0, busy_rise0 = 0, busy_fall0 = 0;
  logic [C0-1:0] cmd_seen0 = '0;
  logic tail_nz0 = 1'b0;
  logic sck0_q = 1'b0, ssel0_q = 1'b1, busy0_q = 1'b0;
  // dut1
  int rises1 = 0, frames1 = 0, valid1 = 0, fall1_cyc = 0, rise1_cyc = 0;
  int gap1 = 0, interval1 = 0;
  logic [C1-1:0] cmd_seen1 = '0;
  logic sck1_q = 1'b0, ssel1_q = 1'b1;

  // Slave presents the next bit before each rise; first bit is the MSB.
  assign miso0 = (rises0 < F0) ? slave0[F0-1-rises0] : 1'b0;
  assign miso1 = (rises1 < F1) ? slave1[F1-1-rises1] : 1'b0;

  always @(negedge clk) begin
    cyc++;
    // dut0
    if (ssel0_q && !ssel0_n) begin
      ssel_fall0 = cyc; rises0 = 0; falls0 = 0; half_err0 = 0;
      tail_nz0 = 1'b0; frames0++;
    end
    if (!ssel0_q && ssel0_n) ssel_rise0 = cyc;
    if (!sck0_q && sck0) begin
      if (rises0 == 0) first_rise0 = cyc;
      else if (cyc - last_edge0 != D0) half_err0++;
      last_edge0 = cyc;
      if (rises0 < C0) cmd_seen0 = {cmd_seen0[C0-2:0], mosi0};
      else if (mosi0) tail_nz0 = 1'b1;
      rises0++;
    end
    if (sck0_q && !sck0) begin
      if (cyc - last_edge0 != D0) half_err0++;
      last_edge0 = cyc; last_fall0 = cyc; falls0++;
    end
    if (!busy0_q && busy0) busy_rise0 = cyc;
    if (busy0_q && !busy0) busy_fall0 = cyc;
    if (valid0_o) valid0++;
    sck0_q = sck0; ssel0_q = ssel0_n; busy0_q = busy0;
    // dut1
    if (ssel1_q && !ssel1_n) begin
      if (frames1 > 0) begin
        gap1 = cyc - rise1_cyc;
        interval1 = cyc - fall1_cyc;
      end
      fall1_cyc = cyc; frames1++; rises1 = 0;
    end
    if (!ssel1_q && ssel1_n) rise1_cyc = cyc;
    if (!sck1_q && sck1) begin
      if (rises1 < C1) cmd_seen1 = {cmd_seen1[C1-2:0], mosi1};
      rises1++;
    end
    if (valid1_o) valid1++;
    sck1_q = sck1; ssel1_q = ssel1_n;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start0(input logic [C0-1:0] cmd);
    cmd0   = cmd;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_idle0(input string tag);
    int n = 0;
    while (busy0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, busy0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_edges0(input int edges);
    int n = 0;
    while ((rises0 + falls0) < edges && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("edge_wait_timeout", ((rises0 + falls0) >= edges), 1'b1);
  endtask

  // Full mode-0 frame timing for dut0: SETUP tick plus the first low
  // half-period precede the first rise (2*D0), HOLD follows the last fall
  // (D0), and SETUP-to-IDLE is (2*128+3)*2 = 518 cycles.
  task automatic check_frame0(input string tag, input logic [C0-1:0] cmd,
                              input logic [F0-1:0] data);
    check({tag, "_mosi_cmd"}, cmd_seen0, cmd);
    check({tag, "_mosi_tail"}, tail_nz0, 1'b0);
    check({tag, "_rx_data"}, rx0, data);
    check({tag, "_rises"}, rises0, 128);
    check({tag, "_falls"}, falls0, 128);
    check({tag, "_half_period"}, half_err0, 0);
    check({tag, "_ssel_to_rise"}, first_rise0 - ssel_fall0, 4);
    check({tag, "_fall_to_ssel"}, ssel_rise0 - last_fall0, 2);
    check({tag, "_frame_len"}, busy_fall0 - busy_rise0, 518);
  endtask

  initial begin
    int f0, v0;
    int n;
    logic [F0-1:0] rx_keep;

    rst0_n = 1'b0; rst1_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    cmd0 = '0; cmd1 = '0;
    slave0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    slave1 = 16'hBEEF;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ssel_n", ssel0_n, 1'b1);
    check("rst_sck", sck0, 1'b0);
    check("rst_mosi", mosi0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_rx_valid", valid0_o, 1'b0);
    check("rst_rx_data", rx0, '0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame
    v0 = valid0;
    pulse_start0(16'hA5C3);
    check("busy_after_accept", busy0, 1'b1);
    wait_idle0("f1");
    check_frame0("f1", 16'hA5C3, slave0);
    check("f1_valid_pulses", valid0 - v0, 1);

    // Repeated start and i_cmd change while busy
    f0 = frames0; v0 = valid0;
    slave0 = 128'hFFFF_0000_AAAA_5555_1234_5678_9ABC_DEF0;
    pulse_start0(16'hA5C3);
    for (int i = 0; i < 20; i++) begin
      cmd0   = 16'h0000;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (15) @(negedge clk);
    end
    wait_idle0("f2");
    check("f2_frames", frames0 - f0, 1);
    check("f2_valid_pulses", valid0 - v0, 1);
    check("f2_mosi_cmd", cmd_seen0, 16'hA5C3);
    check("f2_rx_data", rx0, slave0);

    // Reset at SCK edge 40
    v0 = valid0;
    slave0 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    pulse_start0(16'h5A5A);
    wait_edges0(40);
    rst0_n = 1'b0;
    #1;
    check("mid_rst_ssel_n", ssel0_n, 1'b1);
    check("mid_rst_sck", sck0, 1'b0);
    check("mid_rst_mosi", mosi0, 1'b0);
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_rx_data", rx0, '0);
    @(negedge clk);
    rst0_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_valid", valid0 - v0, 0);

    // First frame after reset
    pulse_start0(16'hFFFF);
    wait_idle0("f3");
    check_frame0("f3", 16'hFFFF, slave0);
    check("f3_valid_pulses", valid0 - v0, 1);

`ifdef SPI_MASTER_ABORT_EN
    // Abort at SCK edge 10
    v0 = valid0;
    rx_keep = rx0;
    slave0 = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    pulse_start0(16'h1234);
    wait_edges0(10);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("abort_ssel_n", ssel0_n, 1'b1);
    check("abort_sck", sck0, 1'b0);
    check("abort_mosi", mosi0, 1'b0);
    wait_idle0("abort");
    check("abort_no_valid", valid0 - v0, 0);
    check("abort_rx_kept", rx0, rx_keep);
`else
    rx_keep = rx0;
`endif

    // Back-to-back frames on dut1: frame is 35 cycles SETUP-to-IDLE, IDLE
    // accepts the held start, so SSEL falls every 36 cycles and stays high
    // for 2 (GAP + accept cycle).
    cmd1   = 16'h3C96;
    start1 = 1'b1;
    n = 0;
    while (frames1 < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    start1 = 1'b0;
    check("b2b_timeout", (frames1 >= 2), 1'b1);
    n = 0;
    while (busy1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("b2b_idle_timeout", busy1, 1'b0);
    repeat (2) @(negedge clk);
    check("b2b_frames", frames1, 2);
    check("b2b_valid_pulses", valid1, 2);
    check("b2b_ssel_gap", gap1, 2);
    check("b2b_interval", interval1, 36);
    check("b2b_mosi_cmd", cmd_seen1, 16'h3C96);
    check("b2b_rx_data", rx1, 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
